// File: rtl/iic_pkg.sv
// Shared definitions for the I2C slave EEPROM: FSM encoding and bus levels.
package iic_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDev,
    StDevAck,
    StWaddr,
    StWaddrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } iic_state_e;

  // Default device-type code matched against device-address bits [7:4].
  localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;

  // Open-drain enable levels: ACK pulls SDA low, NACK releases it.
  localparam logic SDA_ACK  = 1'b1;
  localparam logic SDA_NACK = 1'b0;

endpackage

// File: rtl/iic_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
module iic_bus_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value.
  logic [2:0] r_scl;
  logic [2:0] r_sda;

  // Shift the bus lines in; reset to the idle-high bus level to avoid false edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
  assign o_stop     = r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];

endmodule

// File: rtl/iic_slave_eeprom.sv
// I2C slave EEPROM: 512x8 memory, page-write buffer, timed internal write cycle.
module iic_slave_eeprom
  import iic_pkg::*;
#(
  parameter logic [3:0]  DEV_ID     = DEV_ID_DEFAULT,
  parameter logic [17:0] TWR_CYCLES = 18'd250000,
  parameter int unsigned PAGE_SIZE  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic iic_clk,
  input  logic iic_sda_i,
  output logic iic_sda_oe,
  output logic busy,
  output logic wr_done
);

  localparam int unsigned IdxW = $clog2(PAGE_SIZE);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  iic_bus_sync u_sync (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (iic_clk),
    .i_sda      (iic_sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  iic_state_e r_state, w_state_nxt;
  logic        r_oe, w_oe_nxt;
  logic [3:0]  r_bit_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [8:0]  r_addr, w_addr_nxt;
  logic        r_rw, w_rw_nxt;
  logic        r_mack, w_mack_nxt;
  logic        r_have_data;
  logic        w_buf_wr, w_buf_clr, w_commit, w_load;
  logic        w_rx_state;

  logic [7:0]           r_buf [PAGE_SIZE];
  logic [PAGE_SIZE-1:0] r_valid;
  logic                 r_busy, r_wr_done;
  logic [17:0]          r_twr_cnt;
  logic [8-IdxW:0]      r_page;
  logic [IdxW-1:0]      w_idx, w_cmt_idx;
  logic                 w_mem_we;
  logic [7:0]           r_mem [512];
  logic [7:0]           r_rdata;

  assign w_rx_state = (r_state == StDev) || (r_state == StWaddr) || (r_state == StWdata);
  assign w_idx      = r_addr[IdxW-1:0];
  assign w_cmt_idx  = r_twr_cnt[IdxW-1:0];
  assign w_mem_we   = r_busy && (r_twr_cnt < 18'(PAGE_SIZE)) && r_valid[w_cmt_idx];

  // FSM next state and datapath updates; STOP/START override everything.
  always_comb begin
    w_state_nxt = r_state;
    w_oe_nxt    = r_oe;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_rw_nxt    = r_rw;
    w_mack_nxt  = r_mack;
    w_buf_wr    = 1'b0;
    w_buf_clr   = 1'b0;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    if (w_stop) begin
      w_state_nxt = StIdle;
      w_oe_nxt    = SDA_NACK;
      w_commit    = r_have_data & ~r_busy;
    end else if (w_start) begin
      w_state_nxt = StDev;
      w_oe_nxt    = SDA_NACK;
      w_cnt_nxt   = 4'd0;
    end else begin
      if (w_rx_state && w_scl_rise && r_bit_cnt != 4'd8) begin
        w_shift_nxt = {r_shift[6:0], w_sda};
        w_cnt_nxt   = r_bit_cnt + 4'd1;
      end
      unique case (r_state)
        StIdle: ;
        StDev: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (r_shift[7:4] == DEV_ID && !r_busy) begin
              w_state_nxt   = StDevAck;
              w_oe_nxt      = SDA_ACK;
              w_rw_nxt      = r_shift[0];
              w_addr_nxt[8] = r_shift[1];
            end else begin
              w_state_nxt = StIdle;
              w_oe_nxt    = SDA_NACK;
            end
          end
        end
        StWaddr: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_addr_nxt[7:0] = r_shift;
            w_state_nxt     = StWaddrAck;
            w_oe_nxt        = SDA_ACK;
          end
        end
        StWdata: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_buf_wr                = 1'b1;
            w_addr_nxt[IdxW-1:0]    = r_addr[IdxW-1:0] + 1'b1;
            w_state_nxt             = StWdataAck;
            w_oe_nxt                = SDA_ACK;
          end
        end
        StDevAck, StWaddrAck, StWdataAck: begin
          if (w_scl_fall) begin
            w_oe_nxt  = SDA_NACK;
            w_cnt_nxt = 4'd0;
            if (r_state == StDevAck) begin
              if (r_rw) begin
                w_load = 1'b1;
              end else begin
                w_state_nxt = StWaddr;
                w_buf_clr   = 1'b1;
              end
            end else begin
              w_state_nxt = StWdata;
            end
          end
        end
        StRdata: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_nxt = StRdataAck;
              w_oe_nxt    = SDA_NACK;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
            end
          end
        end
        StRdataAck: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda;
          end else if (w_scl_fall) begin
            if (!r_mack) w_load = 1'b1;
            else         w_state_nxt = StIdle;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
      // Present the prefetched byte: MSB goes out on this SCL fall.
      if (w_load) begin
        w_state_nxt = StRdata;
        w_shift_nxt = r_rdata;
        w_oe_nxt    = ~r_rdata[7];
        w_addr_nxt  = r_addr + 9'd1;
        w_cnt_nxt   = 4'd0;
      end
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_oe        <= SDA_NACK;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_addr      <= 9'd0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_have_data <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_oe      <= w_oe_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_rw      <= w_rw_nxt;
      r_mack    <= w_mack_nxt;
      if (w_commit || w_buf_clr) r_have_data <= 1'b0;
      else if (w_buf_wr)         r_have_data <= 1'b1;
    end
  end

  // Page-buffer valid flags: set on data byte, cleared once committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_buf_clr) begin
      r_valid <= '0;
    end else begin
      if (w_buf_wr) r_valid[w_idx] <= 1'b1;
      if (w_mem_we) r_valid[w_cmt_idx] <= 1'b0;
    end
  end

  // Page-buffer storage.
  always_ff @(posedge clk) begin
    if (w_buf_wr) r_buf[w_idx] <= r_shift;
  end

  // Write-cycle timer: busy for exactly TWR_CYCLES, then a one-clk done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
      r_twr_cnt <= 18'd0;
      r_page    <= '0;
    end else begin
      r_wr_done <= 1'b0;
      if (w_commit) begin
        r_busy    <= 1'b1;
        r_twr_cnt <= 18'd0;
        r_page    <= r_addr[8:IdxW];
      end else if (r_busy) begin
        if (r_twr_cnt == TWR_CYCLES - 18'd1) begin
          r_busy    <= 1'b0;
          r_wr_done <= 1'b1;
        end else begin
          r_twr_cnt <= r_twr_cnt + 18'd1;
        end
      end
    end
  end

  // 512x8 RAM: buffered bytes drain during the first clocks of the write
  // cycle; the read port continuously prefetches the byte at the pointer.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[{r_page, w_cmt_idx}] <= r_buf[w_cmt_idx];
    r_rdata <= r_mem[r_addr];
  end

  assign iic_sda_oe = r_oe;
  assign busy       = r_busy;
  assign wr_done    = r_wr_done;

endmodule

// File: tb/tb_iic_slave_eeprom.sv
// Self-checking bench for iic_slave_eeprom driven by a bit-banged I2C master.
module tb_iic_slave_eeprom;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_bus;
  logic iic_sda_oe, busy, wr_done;
  int   q = 4;
  int   n_checks = 0;
  int   n_fail = 0;

  assign sda_bus = m_sda & ~iic_sda_oe;

  always #5 clk = ~clk;

  iic_slave_eeprom #(
    .DEV_ID     (4'b1010),
    .TWR_CYCLES (18'd100),
    .PAGE_SIZE  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iic_clk    (m_scl),
    .iic_sda_i  (sda_bus),
    .iic_sda_oe (iic_sda_oe),
    .busy       (busy),
    .wr_done    (wr_done)
  );

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_vec_t;

  wr_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    ack = sda_bus; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(); m_scl = 1'b1; wq();
      d[i] = sda_bus; wq();
      m_scl = 1'b0;
    end
    m_sda = nack; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
    m_sda = 1'b1;
  endtask

  // Count busy cycles and done pulses over a window longer than any write cycle.
  task automatic wait_write(output int blen, output int dn);
    blen = 0;
    dn = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) blen++;
      if (wr_done) dn++;
    end
  endtask

  function automatic logic [7:0] dev_byte(input logic [8:0] a, input logic rd);
    return {4'b1010, 2'b00, a[8], rd};
  endfunction

  task automatic set_addr(input logic [8:0] a);
    logic ack;
    i2c_start();
    write_byte(dev_byte(a, 1'b0), ack); check("set_addr dev ack", ack, 1'b0);
    write_byte(a[7:0], ack);            check("set_addr addr ack", ack, 1'b0);
  endtask

  task automatic read_at(input logic [8:0] a, input string name, input logic [7:0] exp);
    logic       ack;
    logic [7:0] d;
    set_addr(a);
    i2c_start();
    write_byte(dev_byte(a, 1'b1), ack); check("read dev ack", ack, 1'b0);
    read_byte(1'b1, d);                 check(name, d, exp);
    i2c_stop();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         blen, dn, seen;

    vecs[0] = '{addr: 9'h005, data: 8'h3C};
    vecs[1] = '{addr: 9'h0AA, data: 8'hC3};
    vecs[2] = '{addr: 9'h100, data: 8'h81};
    vecs[3] = '{addr: 9'h1FF, data: 8'h5A};

    repeat (5) @(negedge clk);
    check("reset sda_oe", iic_sda_oe, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset wr_done", wr_done, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Byte write then random read for each vector.
    for (int v = 0; v < 4; v++) begin
      set_addr(vecs[v].addr);
      write_byte(vecs[v].data, ack); check("byte write data ack", ack, 1'b0);
      i2c_stop();
      wait_write(blen, dn);
      check("byte write busy length", blen, 100);
      check("byte write wr_done pulses", dn, 1);
      read_at(vecs[v].addr, "byte write readback", vecs[v].data);
    end

    // Page write wrapping inside the 16-byte page.
    set_addr(9'h00E);
    write_byte(8'h11, ack); check("page ack 0", ack, 1'b0);
    write_byte(8'h22, ack); check("page ack 1", ack, 1'b0);
    write_byte(8'h33, ack); check("page ack 2", ack, 1'b0);
    write_byte(8'h44, ack); check("page ack 3", ack, 1'b0);
    i2c_stop();
    wait_write(blen, dn);
    check("page busy length", blen, 100);
    read_at(9'h00E, "page mem[00E]", 8'h11);
    read_at(9'h00F, "page mem[00F]", 8'h22);
    read_at(9'h000, "page mem[000]", 8'h33);
    // Pointer now at 001: current-address read.
    i2c_start();
    write_byte(8'hA1, ack); check("current read dev ack", ack, 1'b0);
    read_byte(1'b1, d);     check("current read mem[001]", d, 8'h44);
    i2c_stop();

    // Acknowledge polling.
    set_addr(9'h020);
    write_byte(8'h77, ack); check("poll data ack", ack, 1'b0);
    i2c_stop();
    q = 2;
    i2c_start();
    write_byte(8'hA0, ack);
    check("poll busy during address", busy, 1'b1);
    check("poll NACK while busy", ack, 1'b1);
    i2c_stop();
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (wr_done) seen = 1;
    end
    check("poll wr_done seen", seen, 1);
    i2c_start();
    write_byte(8'hA0, ack); check("poll ACK after done", ack, 1'b0);
    i2c_stop();
    q = 4;
    wait_write(blen, dn);
    check("poll empty stop no busy", blen, 0);
    read_at(9'h020, "poll mem[020]", 8'h77);

    // Wrong device ID: NACK and slave stays quiet.
    i2c_start();
    write_byte(8'h90, ack); check("wrong id NACK", ack, 1'b1);
    write_byte(8'h00, ack); check("wrong id idle 1", ack, 1'b1);
    write_byte(8'h99, ack); check("wrong id idle 2", ack, 1'b1);
    i2c_stop();
    wait_write(blen, dn);
    check("wrong id no write", blen, 0);
    read_at(9'h000, "wrong id mem[000] kept", 8'h33);

    // Sequential read across the 0x1FF -> 0x000 wrap.
    set_addr(9'h1FF);
    i2c_start();
    write_byte(8'hA3, ack); check("seq dev ack", ack, 1'b0);
    read_byte(1'b0, d);     check("seq mem[1FF]", d, 8'h5A);
    read_byte(1'b0, d);     check("seq mem[000]", d, 8'h33);
    read_byte(1'b1, d);     check("seq mem[001]", d, 8'h44);
    i2c_stop();

    // Reset in the middle of a data byte's ACK.
    set_addr(9'h040);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    repeat (2) @(negedge clk);
    check("mid write slave acking", iic_sda_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid write reset sda_oe", iic_sda_oe, 1'b0);
    check("mid write reset busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    i2c_start();
    write_byte(8'hA0, ack); check("after reset dev ack", ack, 1'b0);
    write_byte(8'h40, ack); check("after reset addr ack", ack, 1'b0);
    i2c_stop();
    wait_write(blen, dn);
    check("after reset no commit", blen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave_eeprom.md
IIC_SLAVE_EEPROM -- requirements
Module: iic_slave_eeprom

Interface
REQ-001 Parameter DEV_ID, default 4'b1010, device-type code matched against device-address bits [7:4].
REQ-002 Parameter TWR_CYCLES, default 18'd250000, internal write-cycle duration in clk cycles (5 ms at 50 MHz).
REQ-003 Parameter PAGE_SIZE, default 16, page-write buffer depth in bytes.
REQ-004 clk  input  1  system clock; iic_clk and iic_sda are oversampled on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 iic_clk  input  1  bus SCL, asynchronous to clk.
REQ-007 iic_sda_i  input  1  bus SDA level, asynchronous to clk.
REQ-008 iic_sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
REQ-009 busy  output  1  high while the internal write cycle runs.
REQ-010 wr_done  output  1  one-clk pulse when a write cycle completes.

Function
REQ-011 SCL and SDA SHALL each pass a 2-flop synchronizer; edges are detected on synchronized values; bus event to internal reaction latency is 3 clk.
REQ-012 START (SDA falling while SCL high) SHALL force state DEV and clear the bit counter, from any state, including repeated START.
REQ-013 STOP (SDA rising while SCL high) SHALL force state IDLE from any state and release SDA.
REQ-014 Data bits SHALL be sampled on synchronized SCL rising, MSB first; SDA drive changes only on synchronized SCL falling.
REQ-015 States: IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 DEV: after 8 bits, ACK (drive low for the 9th SCL period) only if bits[7:4]==DEV_ID and busy==0; otherwise release SDA and return to IDLE.
REQ-017 Device-address bit[1] SHALL set word-address bit 8 (block select); bits [3:2] are ignored.
REQ-018 R/W=0: go to WADDR; 8 bits load word-address [7:0]; ACK; then WDATA.
REQ-019 WDATA: each byte is ACKed and stored in the page buffer; the low 4 address bits increment and wrap within the 16-byte page; bytes beyond PAGE_SIZE overwrite earlier buffered bytes.
REQ-020 STOP after at least one complete WDATA byte SHALL commit the buffer to memory, assert busy for exactly TWR_CYCLES clk, then pulse wr_done; STOP with no data byte commits nothing.
REQ-021 R/W=1: go to RDATA; shift out mem[address], then increment the 9-bit address with wrap 0x1FF -> 0x000.
REQ-022 RDATA_ACK: master ACK (SDA low) -> next byte; master NACK -> release SDA, go to IDLE.
REQ-023 While busy, every device address SHALL be NACKed (acknowledge polling).
REQ-024 Address counter SHALL persist between transactions (current-address read).

Reset
REQ-025 rst SHALL force IDLE, iic_sda_oe=0, busy=0, wr_done=0, address=0, empty buffer; memory contents are unspecified.
REQ-026 rst during a write cycle SHALL abort it; partially committed memory contents are undefined.

Structure
REQ-027 A shared package iic_pkg SHALL hold the state encoding, DEV_ID default, and ACK/NACK level constants.
REQ-028 Sub-module iic_bus_sync SHALL hold the synchronizers and scl_rise, scl_fall, start, and stop detection.
REQ-029 Memory SHALL be a 512x8 inferred synchronous RAM with 1-clk read latency; the read byte is loaded before SCL falls for bit 7.

Verification (bench uses TWR_CYCLES=100 and a pullup on SDA)
REQ-030 Byte write A0,05,3C,STOP -> three ACKs, busy high 100 clk, wr_done pulse; then A0,05,rS,A1 read -> 0x3C, NACK.
REQ-031 Page wrap: A0,0E then 11,22,33,44,STOP -> mem[0E]=11, mem[0F]=22, mem[00]=33, mem[01]=44.
REQ-032 Polling: A0 sent during busy -> NACK; A0 sent after wr_done -> ACK.
REQ-033 Wrong ID 0x90 -> NACK on the 9th clock, return to IDLE, no memory change.
REQ-034 Sequential read from A3 after setting address 0xFF with block bit set, 3 bytes -> returns mem[1FF], mem[000], mem[001].
REQ-035 rst asserted mid-WDATA -> iic_sda_oe=0 and IDLE within 1 clk; next START is ACKed normally.
